// File: rtl/wasm_instr_loader_if.sv
// Byte-stream handshake plus instruction BRAM write port for the WASM program loader.
// slave = the loader's view, master = the upstream source / BRAM side.
interface wasm_instr_loader_if #(
   parameter int unsigned ADDR_W = 10
);
   logic              i_byte_valid;
   logic [7:0]        i_byte_data;
   logic              o_byte_ready;
   logic              o_bram_we;
   logic [ADDR_W-1:0] o_bram_addr;
   logic [7:0]        o_bram_wdata;

   modport slave (
      input  i_byte_valid,
      input  i_byte_data,
      output o_byte_ready,
      output o_bram_we,
      output o_bram_addr,
      output o_bram_wdata
   );

   modport master (
      output i_byte_valid,
      output i_byte_data,
      input  o_byte_ready,
      input  o_bram_we,
      input  o_bram_addr,
      input  o_bram_wdata
   );
endinterface

// File: rtl/wasm_instr_loader.sv
// Loads a length-prefixed byte frame into instruction BRAM and releases the WASM core reset.
// Optional trailing XOR checksum byte is enabled by defining WASM_LOADER_CHECKSUM_EN.
module wasm_instr_loader #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   wasm_instr_loader_if.slave   bus,
   output logic                 o_load_done,
   output logic                 o_load_error,
   output logic                 o_cpu_rst_n
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LEN_LO = 3'd1;
   localparam logic [2:0] LEN_HI = 3'd2;
   localparam logic [2:0] DATA   = 3'd3;
`ifdef WASM_LOADER_CHECKSUM_EN
   localparam logic [2:0] CSUM   = 3'd4;
`endif
   localparam logic [2:0] DONE   = 3'd5;
   localparam logic [2:0] ERR    = 3'd6;

   localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

   logic [2:0]        state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              bram_we_q, bram_we_d;
   logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
   logic [7:0]        bram_wdata_q, bram_wdata_d;
`ifdef WASM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   logic        loading;
   logic        accept;
   logic [15:0] len_full;
   logic        last_byte;

   always_comb begin
      loading = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
`ifdef WASM_LOADER_CHECKSUM_EN
      loading = loading || (state_q == CSUM);
`endif
   end

   assign accept    = loading && bus.i_byte_valid;
   assign len_full  = {bus.i_byte_data, len_q[7:0]};
   // Counter is one bit wider than the address so N = 2^ADDR_W terminates without wrapping.
   assign last_byte = ((32'(cnt_q) + 32'd1) == 32'(len_q));

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      bram_we_d    = 1'b0;
      bram_addr_d  = bram_addr_q;
      bram_wdata_d = bram_wdata_q;
`ifdef WASM_LOADER_CHECKSUM_EN
      csum_d       = csum_q;
`endif
      case (state_q)
         IDLE, DONE, ERR: begin
            if (i_start) begin
               state_d = LEN_LO;
               len_d   = '0;
               cnt_d   = '0;
`ifdef WASM_LOADER_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         LEN_LO: begin
            if (accept) begin
               len_d[7:0] = bus.i_byte_data;
               state_d    = LEN_HI;
            end
         end
         LEN_HI: begin
            if (accept) begin
               len_d[15:8] = bus.i_byte_data;
               if ((len_full == 16'd0) || (32'(len_full) > DEPTH)) begin
                  state_d = ERR;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               bram_we_d    = 1'b1;
               bram_addr_d  = cnt_q[ADDR_W-1:0];
               bram_wdata_d = bus.i_byte_data;
               cnt_d        = cnt_q + 1'b1;
`ifdef WASM_LOADER_CHECKSUM_EN
               csum_d       = csum_q ^ bus.i_byte_data;
               if (last_byte) state_d = CSUM;
`else
               if (last_byte) state_d = DONE;
`endif
            end
         end
`ifdef WASM_LOADER_CHECKSUM_EN
         CSUM: begin
            if (accept) begin
               state_d = (bus.i_byte_data == csum_q) ? DONE : ERR;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         len_q        <= '0;
         cnt_q        <= '0;
         bram_we_q    <= 1'b0;
         bram_addr_q  <= '0;
         bram_wdata_q <= '0;
`ifdef WASM_LOADER_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         bram_we_q    <= bram_we_d;
         bram_addr_q  <= bram_addr_d;
         bram_wdata_q <= bram_wdata_d;
`ifdef WASM_LOADER_CHECKSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   assign bus.o_byte_ready = loading;
   assign bus.o_bram_we    = bram_we_q;
   assign bus.o_bram_addr  = bram_addr_q;
   assign bus.o_bram_wdata = bram_wdata_q;
   assign o_load_done      = (state_q == DONE);
   assign o_load_error     = (state_q == ERR);
   assign o_cpu_rst_n      = (state_q == DONE);

endmodule

// File: tb/tb_wasm_instr_loader.sv
// Randomized self-checking bench for wasm_instr_loader against a frame-level reference model.
module tb_wasm_instr_loader;

   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 1 << AW;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      int unsigned addr;
      logic [7:0]  data;
      int unsigned cyc;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0;
   logic load_done, load_error, cpu_rst_n;

   wasm_instr_loader_if #(.ADDR_W(AW)) bus ();

   wasm_instr_loader #(.ADDR_W(AW)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .bus          (bus),
      .o_load_done  (load_done),
      .o_load_error (load_error),
      .o_cpu_rst_n  (cpu_rst_n)
   );

   always #5 clk = ~clk;

   wr_t         exp_q[$];
   logic [7:0]  exp_mem [DEPTH];
   logic [7:0]  obs_mem [DEPTH];
   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Every BRAM write must match the next payload byte accepted one edge earlier.
   always @(negedge clk) begin
      wr_t e;
      if (bus.o_bram_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_we", {31'd0, bus.o_bram_we}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(bus.o_bram_addr), e.addr);
            chk("wr_data", 32'(bus.o_bram_wdata), 32'(e.data));
            chk("wr_cycle", cyc, e.cyc);
            obs_mem[bus.o_bram_addr] = bus.o_bram_wdata;
         end
      end
   end

   task automatic push_byte(input logic [7:0] b, input int stall, input int idx);
      for (int s = 0; s < 6 && stall > 0 && $urandom_range(99) < stall; s++) begin
         bus.i_byte_valid = 1'b0;
         start = ($urandom_range(3) == 0);
         @(posedge clk); #1;
         start = 1'b0;
         chk("ready_hold", {31'd0, bus.o_byte_ready}, 32'd1);
      end
      bus.i_byte_valid = 1'b1;
      bus.i_byte_data  = b;
      chk("ready", {31'd0, bus.o_byte_ready}, 32'd1);
      @(posedge clk); #1;
      if (idx >= 0) begin
         exp_q.push_back('{addr: idx, data: b, cyc: cyc});
         exp_mem[idx] = b;
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_done", {31'd0, load_done}, 32'd0);
      chk("start_err", {31'd0, load_error}, 32'd0);
      chk("start_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
      chk("start_ready", {31'd0, bus.o_byte_ready}, 32'd1);
   endtask

   // cs_mode: 0 = correct checksum, 1 = send cs_val, 2 = corrupted checksum
   task automatic run_frame(input logic [15:0] n, input bq_t pl, input int stall,
                            input int cs_mode, input logic [7:0] cs_val);
      logic [7:0] x;
      logic [7:0] cs;
      bit ok;
      x  = 8'h00;
      ok = (n != 16'd0) && (32'(n) <= DEPTH);
      do_start();
      push_byte(n[7:0], stall, -1);
      push_byte(n[15:8], stall, -1);
      if (ok) begin
         for (int i = 0; i < int'(n); i++) begin
            push_byte(pl[i], stall, i);
            x ^= pl[i];
         end
`ifdef WASM_LOADER_CHECKSUM_EN
         cs = (cs_mode == 1) ? cs_val : (cs_mode == 2) ? (x ^ 8'h5A) : x;
         push_byte(cs, stall, -1);
         ok = (cs == x);
`else
         cs = cs_val;
         if (cs_mode < 0) ok = 1'b0;
`endif
      end
      bus.i_byte_valid = 1'b0;
      chk("load_done", {31'd0, load_done}, {31'd0, ok});
      chk("load_error", {31'd0, load_error}, {31'd0, !ok});
      chk("cpu_rst_n", {31'd0, cpu_rst_n}, {31'd0, ok});
      chk("ready_after", {31'd0, bus.o_byte_ready}, 32'd0);
      repeat (2) begin @(posedge clk); #1; end
      chk("writes_pending", exp_q.size(), 32'd0);
      chk("status_hold", {31'd0, load_done}, {31'd0, ok});
      for (int i = 0; i < int'(DEPTH); i++) chk("mem", 32'(obs_mem[i]), 32'(exp_mem[i]));
   endtask

   function automatic bq_t rand_payload(input int n);
      bq_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255)));
      return q;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bq_t pl;
      int  n;
      for (int i = 0; i < int'(DEPTH); i++) begin
         exp_mem[i] = 8'h00;
         obs_mem[i] = 8'h00;
      end
      bus.i_byte_valid = 1'b0;
      bus.i_byte_data  = 8'h00;

      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", {31'd0, bus.o_byte_ready}, 32'd0);
      chk("rst_we", {31'd0, bus.o_bram_we}, 32'd0);
      chk("rst_done", {31'd0, load_done}, 32'd0);
      chk("rst_err", {31'd0, load_error}, 32'd0);
      chk("rst_cpu", {31'd0, cpu_rst_n}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      pl = '{8'h41, 8'h20, 8'h0B};
      run_frame(16'd3, pl, 0, 0, 8'h00);

      pl = {};
      run_frame(16'd0, pl, 0, 0, 8'h00);
      run_frame(16'd17, pl, 0, 0, 8'h00);

      pl = rand_payload(16);
      run_frame(16'd16, pl, 0, 0, 8'h00);

`ifdef WASM_LOADER_CHECKSUM_EN
      pl = '{8'h41, 8'h20, 8'h0B};
      run_frame(16'd3, pl, 0, 1, 8'h00);
      pl = rand_payload(7);
      run_frame(16'd7, pl, 30, 2, 8'h00);
`endif

      for (int f = 0; f < 6; f++) begin
         n  = $urandom_range(1, DEPTH);
         pl = rand_payload(n);
         run_frame(16'(n), pl, 40, 0, 8'h00);
      end

      for (int f = 0; f < 3; f++) begin
         pl = {};
         run_frame(16'($urandom_range(DEPTH + 1, 65535)), pl, 30, 0, 8'h00);
      end

      // Reset mid-payload, then a clean reload.
      pl = rand_payload(5);
      do_start();
      push_byte(8'h05, 0, -1);
      push_byte(8'h00, 0, -1);
      push_byte(pl[0], 0, 0);
      push_byte(pl[1], 0, 1);
      bus.i_byte_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", {31'd0, bus.o_byte_ready}, 32'd0);
      chk("mid_rst_we", {31'd0, bus.o_bram_we}, 32'd0);
      chk("mid_rst_addr", 32'(bus.o_bram_addr), 32'd0);
      chk("mid_rst_wdata", 32'(bus.o_bram_wdata), 32'd0);
      chk("mid_rst_done", {31'd0, load_done}, 32'd0);
      chk("mid_rst_err", {31'd0, load_error}, 32'd0);
      chk("mid_rst_cpu", {31'd0, cpu_rst_n}, 32'd0);
      bus.i_byte_valid = 1'b1;
      bus.i_byte_data  = 8'($urandom_range(255));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      chk("post_rst_ready", {31'd0, bus.o_byte_ready}, 32'd0);
      chk("post_rst_pending", exp_q.size(), 32'd0);
      bus.i_byte_valid = 1'b0;
      n  = $urandom_range(1, DEPTH);
      pl = rand_payload(n);
      run_frame(16'(n), pl, 20, 0, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
